id_stage_p: RTL and testbench
=============================

Name: id_stage_p

Overview:
- Parametrised second-generation instruction-decode stage for the 5-stage MIPS pipeline.
- Holds the IF/ID pipeline register, a parametrised register file, opcode decode and two-source forwarding (E, M).
- Detects Tuse/Tnew hazards and raises stall; resolves branches and jumps in D with a selectable delay-slot mode.
- Sits between fetch and the ID/EX register. Adds stall generation, bubble insertion, bne/blez/bgtz/jr/jal and non-delay-slot flush, which the previous decode stage lacked.

Parameters:
XLEN, 32, datapath width (>=32)
NREG, 32, register count (power of two; AW = log2(NREG))
RESET_PC, 32'h0000_3000, pc_d value after reset
DELAY_SLOT, 1, 1 = MIPS delay slot; 0 = taken branch/jump flushes the IF/ID register

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
instr_f  in  32  instruction from fetch
pc_f  in  XLEN  PC of instr_f
wb_we  in  1  W-stage register write enable
wb_addr  in  AW  W-stage destination
wb_data  in  XLEN  W-stage data
e_addr  in  AW  E-stage destination (0 = none)
e_tnew  in  2  E-stage remaining Tnew
e_data  in  XLEN  E-stage forwardable result
m_addr, m_tnew, m_data  in  AW/2/XLEN  same fields for the M stage
stall  out  1  hold PC and IF/ID; the ID/EX register must load a bubble
valid_d  out  1  0 when the D slot is a bubble
instr_d  out  32  IF/ID instruction
pc_d  out  XLEN  IF/ID PC
rs_val, rt_val  out  XLEN  forwarded operands
imm_ext  out  XLEN  zero-extended for ori; imm<<16 for lui; sign-extended otherwise
dst_d  out  AW  destination: rd for R-type, rt for I-type, 31 for jal, 0 otherwise
tnew_d  out  2  ALU/lui = 2, lw = 3, jal = 1, others = 0
npc_sel  out  1  1 = redirect fetch to npc
npc  out  XLEN  branch/jump target

Behaviour:
- Reset (asynchronous): instr_d = 0, pc_d = RESET_PC, valid_d = 0, all registers = 0. All outputs are then derived from these values: stall = 0, npc_sel = 0.
- IF/ID register, rising edge:
  - stall = 1: hold.
  - else DELAY_SLOT = 0 and npc_sel = 1: load instr 0, valid 0.
  - else: load instr_f/pc_f, valid 1.
- Register file:
  - Write on clk edge when wb_we && wb_addr != 0.
  - Register 0 always reads 0.
  - Same-cycle read of wb_addr returns wb_data (write-first bypass).
- Decoded set: addu, subu, ori, lui, lw, sw, beq, bne, blez, bgtz, j, jal, jr, nop. Any other opcode decodes as nop with valid_d kept.
- Tuse values:
  - addu/subu: rs = rt = 1.
  - ori/lw: rs = 1.
  - sw: rs = 1, rt = 2.
  - beq/bne: rs = rt = 0.
  - blez/bgtz/jr: rs = 0.
  - Unused operand: Tuse = 3 (never stalls).
- stall is combinational. It is asserted when valid_d is set and, for either operand r with nonzero address:
  - e_addr == r && Tuse(r) < e_tnew, or
  - m_addr == r && Tuse(r) < m_tnew.
- Forward priority (per operand, address != 0):
  1. E when e_addr matches and e_tnew == 0.
  2. Else M when m_addr matches and m_tnew == 0.
  3. Else register file.
  - A match with tnew > 0 that does not stall falls through to the next source.
- Branch and jump resolution (all gated by !stall && valid_d):
  - beq: equal; bne: not equal; blez: signed rs <= 0; bgtz: signed rs > 0.
  - Branch target = pc_d + 4 + (sign-extended imm << 2).
  - j/jal target = {pc_d+4[31:28], index, 2'b00}; jr target = rs_val.
  - npc_sel = 1 for a taken branch or any jump.
- jal link value pc_d + 8 is produced downstream; tnew_d = 1 for jal.
- Arithmetic is modulo 2^XLEN; the upper XLEN-32 bits of the jump target come from pc_d.
- Simultaneous wb write and E/M match on the same register: E/M has priority.
- Reset mid-stall: IF/ID clears immediately and stall drops.

Test Plan:
- Reset with pc_f = 0x3004 → pc_d = 0x3000, instr_d = 0, stall = 0, npc_sel = 0; rs_val = 0 for every address.
- wb_we = 1, wb_addr = 5, wb_data = 0x1234; decode addu $6, $5, $0 in the same cycle → rs_val = 0x1234 (bypass). Write to $0 leaves $0 = 0.
- lw in E (e_addr = 8, e_tnew = 2), beq $8, $9 in D → stall = 1, IF/ID held, npc_sel = 0.
  - Next cycles: E tnew 1 → still stall. M tnew 0, m_data = 7, $9 = 7 → stall = 0, npc_sel = 1, npc = pc_d + 4 + (imm << 2).
- e_addr = m_addr = 3, both tnew 0, e_data = 0xA, m_data = 0xB → rs_val = 0xA.
- DELAY_SLOT = 0: jal at pc_d = 0x3010 with index 0x100 → npc = 0x400; next cycle valid_d = 0, instr_d = 0.
  - DELAY_SLOT = 1: same jal → next instruction is loaded normally.
- bgtz with rs = 0x8000_0000 → not taken; blez with the same rs → taken. jr with rs = 0x3020 → npc = 0x3020.

Source files
------------

// File: rtl/id_stage_p_if.sv
// Decode-stage bus: fetch inputs, W/E/M feedback and decoded outputs.
// The stage uses the slave modport; the surrounding pipeline uses master.
interface id_stage_p_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  localparam int AW = $clog2(NREG);

  logic [31:0]     instr_f;
  logic [XLEN-1:0] pc_f;
  logic            wb_we;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic [AW-1:0]   e_addr;
  logic [1:0]      e_tnew;
  logic [XLEN-1:0] e_data;
  logic [AW-1:0]   m_addr;
  logic [1:0]      m_tnew;
  logic [XLEN-1:0] m_data;

  logic            stall;
  logic            valid_d;
  logic [31:0]     instr_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic [XLEN-1:0] imm_ext;
  logic [AW-1:0]   dst_d;
  logic [1:0]      tnew_d;
  logic            npc_sel;
  logic [XLEN-1:0] npc;

  modport master (
    output instr_f, pc_f, wb_we, wb_addr, wb_data,
    output e_addr, e_tnew, e_data, m_addr, m_tnew, m_data,
    input  stall, valid_d, instr_d, pc_d, rs_val, rt_val,
    input  imm_ext, dst_d, tnew_d, npc_sel, npc
  );

  modport slave (
    input  instr_f, pc_f, wb_we, wb_addr, wb_data,
    input  e_addr, e_tnew, e_data, m_addr, m_tnew, m_data,
    output stall, valid_d, instr_d, pc_d, rs_val, rt_val,
    output imm_ext, dst_d, tnew_d, npc_sel, npc
  );
endinterface

// File: rtl/id_stage_p.sv
// MIPS decode stage: IF/ID register, regfile, E/M forwarding,
// Tuse/Tnew stall and branch/jump resolution with optional delay slot.
module id_stage_p #(
  parameter int              XLEN       = 32,
  parameter int              NREG       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(32'h0000_3000),
  parameter int              DELAY_SLOT = 1
) (
  input logic         clk,
  input logic         reset,
  id_stage_p_if.slave bus
);
  localparam int AW = $clog2(NREG);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_BLEZ = 6'h06;
  localparam logic [5:0] OP_BGTZ = 6'h07;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q;
  logic            valid_q;
  logic [XLEN-1:0] rf [NREG];

  logic            stall;
  logic            npc_sel;

  logic [5:0]      op;
  logic [5:0]      fn;
  logic [AW-1:0]   rs_a;
  logic [AW-1:0]   rt_a;
  logic [AW-1:0]   rd_a;
  logic [15:0]     imm;

  assign op   = instr_q[31:26];
  assign fn   = instr_q[5:0];
  assign rs_a = instr_q[21 +: AW];
  assign rt_a = instr_q[16 +: AW];
  assign rd_a = instr_q[11 +: AW];
  assign imm  = instr_q[15:0];

  logic is_addu, is_subu, is_jr, is_ori, is_lui, is_lw;
  logic is_sw, is_beq, is_bne, is_blez, is_bgtz, is_j, is_jal;

  assign is_addu = (op == OP_R) && (fn == FN_ADDU);
  assign is_subu = (op == OP_R) && (fn == FN_SUBU);
  assign is_jr   = (op == OP_R) && (fn == FN_JR);
  assign is_ori  = (op == OP_ORI);
  assign is_lui  = (op == OP_LUI);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_beq  = (op == OP_BEQ);
  assign is_bne  = (op == OP_BNE);
  assign is_blez = (op == OP_BLEZ);
  assign is_bgtz = (op == OP_BGTZ);
  assign is_j    = (op == OP_J);
  assign is_jal  = (op == OP_JAL);

  logic [1:0]    tuse_rs;
  logic [1:0]    tuse_rt;
  logic [AW-1:0] dst;
  logic [1:0]    tnew;

  // Tuse of 3 marks an unused operand; no Tnew exceeds 3 so it never stalls.
  always_comb begin
    tuse_rs = 2'd3;
    tuse_rt = 2'd3;
    dst     = '0;
    tnew    = 2'd0;
    unique case (1'b1)
      is_addu, is_subu: begin
        tuse_rs = 2'd1;
        tuse_rt = 2'd1;
        dst     = rd_a;
        tnew    = 2'd2;
      end
      is_ori: begin
        tuse_rs = 2'd1;
        dst     = rt_a;
        tnew    = 2'd2;
      end
      is_lui: begin
        dst  = rt_a;
        tnew = 2'd2;
      end
      is_lw: begin
        tuse_rs = 2'd1;
        dst     = rt_a;
        tnew    = 2'd3;
      end
      is_sw: begin
        tuse_rs = 2'd1;
        tuse_rt = 2'd2;
      end
      is_beq, is_bne: begin
        tuse_rs = 2'd0;
        tuse_rt = 2'd0;
      end
      is_blez, is_bgtz, is_jr: tuse_rs = 2'd0;
      is_jal: begin
        dst  = AW'(31);
        tnew = 2'd1;
      end
      default: ;
    endcase
  end

  function automatic logic haz(
    input logic [AW-1:0] a,
    input logic [1:0]    tu,
    input logic [AW-1:0] ea,
    input logic [1:0]    et,
    input logic [AW-1:0] ma,
    input logic [1:0]    mt
  );
    return (a != '0) &&
           (((ea == a) && (tu < et)) ||
            ((ma == a) && (tu < mt)));
  endfunction

  assign stall = valid_q && (
    haz(rs_a, tuse_rs, bus.e_addr, bus.e_tnew,
        bus.m_addr, bus.m_tnew) ||
    haz(rt_a, tuse_rt, bus.e_addr, bus.e_tnew,
        bus.m_addr, bus.m_tnew));

  // E/M results outrank the W write-first bypass for the same register.
  function automatic logic [XLEN-1:0] fwd(
    input logic [AW-1:0]   a,
    input logic [XLEN-1:0] rf_val,
    input logic [AW-1:0]   ea,
    input logic [1:0]      et,
    input logic [XLEN-1:0] ed,
    input logic [AW-1:0]   ma,
    input logic [1:0]      mt,
    input logic [XLEN-1:0] md,
    input logic            we,
    input logic [AW-1:0]   wa,
    input logic [XLEN-1:0] wd
  );
    if (a == '0)                    return '0;
    if ((ea == a) && (et == 2'd0))  return ed;
    if ((ma == a) && (mt == 2'd0))  return md;
    if (we && (wa == a))            return wd;
    return rf_val;
  endfunction

  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;

  assign rs_val = fwd(rs_a, rf[rs_a],
    bus.e_addr, bus.e_tnew, bus.e_data,
    bus.m_addr, bus.m_tnew, bus.m_data,
    bus.wb_we, bus.wb_addr, bus.wb_data);
  assign rt_val = fwd(rt_a, rf[rt_a],
    bus.e_addr, bus.e_tnew, bus.e_data,
    bus.m_addr, bus.m_tnew, bus.m_data,
    bus.wb_we, bus.wb_addr, bus.wb_data);

  logic [XLEN-1:0] sext;
  logic [XLEN-1:0] imm_ext;

  assign sext = {{(XLEN-16){imm[15]}}, imm};

  always_comb begin
    imm_ext = sext;
    unique case (1'b1)
      is_ori:  imm_ext = XLEN'(imm);
      is_lui:  imm_ext = XLEN'({imm, 16'h0000});
      default: ;
    endcase
  end

  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] j_tgt;
  logic [XLEN-1:0] npc;
  logic            rs_neg;
  logic            rs_zero;
  logic            taken;

  assign pc4     = pc_q + XLEN'(4);
  assign br_tgt  = pc4 + {sext[XLEN-3:0], 2'b00};
  assign rs_neg  = rs_val[XLEN-1];
  assign rs_zero = (rs_val == '0);

  always_comb begin
    j_tgt       = pc_q;
    j_tgt[31:0] = {pc4[31:28], instr_q[25:0], 2'b00};
  end

  always_comb begin
    taken = 1'b0;
    npc   = br_tgt;
    unique case (1'b1)
      is_beq:        taken = (rs_val == rt_val);
      is_bne:        taken = (rs_val != rt_val);
      is_blez:       taken = rs_neg || rs_zero;
      is_bgtz:       taken = !rs_neg && !rs_zero;
      is_j, is_jal: begin
        taken = 1'b1;
        npc   = j_tgt;
      end
      is_jr: begin
        taken = 1'b1;
        npc   = rs_val;
      end
      default: ;
    endcase
  end

  assign npc_sel = taken && valid_q && !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= '0;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else if (!stall) begin
      pc_q <= bus.pc_f;
      if ((DELAY_SLOT == 0) && npc_sel) begin
        instr_q <= '0;
        valid_q <= 1'b0;
      end else begin
        instr_q <= bus.instr_f;
        valid_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (bus.wb_we && (bus.wb_addr != '0)) begin
      rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  assign bus.stall   = stall;
  assign bus.valid_d = valid_q;
  assign bus.instr_d = instr_q;
  assign bus.pc_d    = pc_q;
  assign bus.rs_val  = rs_val;
  assign bus.rt_val  = rt_val;
  assign bus.imm_ext = imm_ext;
  assign bus.dst_d   = dst;
  assign bus.tnew_d  = tnew;
  assign bus.npc_sel = npc_sel;
  assign bus.npc     = npc;
endmodule

// File: tb/tb_id_stage_p.sv
// Directed bench for id_stage_p: u0 runs with delay slot, u1 without;
// both see identical inputs.
module tb_id_stage_p;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  id_stage_p_if #(.XLEN(32), .NREG(32)) b0 ();
  id_stage_p_if #(.XLEN(32), .NREG(32)) b1 ();

  assign b1.instr_f = b0.instr_f;
  assign b1.pc_f    = b0.pc_f;
  assign b1.wb_we   = b0.wb_we;
  assign b1.wb_addr = b0.wb_addr;
  assign b1.wb_data = b0.wb_data;
  assign b1.e_addr  = b0.e_addr;
  assign b1.e_tnew  = b0.e_tnew;
  assign b1.e_data  = b0.e_data;
  assign b1.m_addr  = b0.m_addr;
  assign b1.m_tnew  = b0.m_tnew;
  assign b1.m_data  = b0.m_data;

  id_stage_p #(.DELAY_SLOT(1)) u0 (
    .clk(clk), .reset(reset), .bus(b0.slave));
  id_stage_p #(.DELAY_SLOT(0)) u1 (
    .clk(clk), .reset(reset), .bus(b1.slave));

  function automatic logic [31:0] rtype(
    input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(
    input logic [5:0] op, input int rs, input int rt,
    input logic [15:0] imm);
    return {op, rs[4:0], rt[4:0], imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b0.wb_we = 0; b0.e_addr = 0; b0.e_tnew = 0;
    b0.m_addr = 0; b0.m_tnew = 0;
    b0.instr_f = 0; b0.pc_f = 32'h3000;
    tick();
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    b0.wb_we = 1; b0.wb_addr = a[4:0]; b0.wb_data = d;
    tick();
    b0.wb_we = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    b0.instr_f = rtype(1, 2, 3, 6'h21); b0.pc_f = 32'h3004;
    b0.wb_we = 0; b0.wb_addr = 0; b0.wb_data = 0;
    b0.e_addr = 0; b0.e_tnew = 0; b0.e_data = 0;
    b0.m_addr = 0; b0.m_tnew = 0; b0.m_data = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (b0.pc_d !== 32'h3000) begin n_bad++;
      $display("FAIL rst_pc: got %h want 3000", b0.pc_d); end
    n_cmp++; if (b0.instr_d !== 32'h0) begin n_bad++;
      $display("FAIL rst_instr: got %h want 0", b0.instr_d); end
    n_cmp++; if (b0.valid_d !== 1'b0) begin n_bad++;
      $display("FAIL rst_valid: got %b want 0", b0.valid_d); end
    n_cmp++; if (b0.stall !== 1'b0) begin n_bad++;
      $display("FAIL rst_stall: got %b want 0", b0.stall); end
    n_cmp++; if (b0.npc_sel !== 1'b0) begin n_bad++;
      $display("FAIL rst_npcsel: got %b want 0", b0.npc_sel); end
    reset = 0;
    for (int i = 0; i < 32; i++) begin
      b0.instr_f = rtype(i, 0, 0, 6'h21);
      tick();
      n_cmp++; if (b0.rs_val !== 32'h0) begin n_bad++;
        $display("FAIL rst_rf%0d: got %h want 0", i, b0.rs_val); end
    end
  endtask

  task automatic test_bypass();
    idle();
    b0.instr_f = rtype(5, 0, 6, 6'h21);
    tick();
    b0.wb_we = 1; b0.wb_addr = 5; b0.wb_data = 32'h1234;
    #1;
    n_cmp++; if (b0.rs_val !== 32'h1234) begin n_bad++;
      $display("FAIL wb_bypass: got %h want 1234", b0.rs_val); end
    n_cmp++; if (b0.dst_d !== 5'd6 || b0.tnew_d !== 2'd2) begin n_bad++;
      $display("FAIL addu_dec: got %0d/%0d want 6/2", b0.dst_d, b0.tnew_d); end
    tick();
    b0.wb_we = 0;
    #1;
    n_cmp++; if (b0.rs_val !== 32'h1234) begin n_bad++;
      $display("FAIL rf_read: got %h want 1234", b0.rs_val); end
    b0.instr_f = rtype(0, 5, 6, 6'h23);
    wr(0, 32'hffff);
    #1;
    n_cmp++; if (b0.rs_val !== 32'h0 || b0.rt_val !== 32'h1234) begin
      n_bad++;
      $display("FAIL r0_write: got %h/%h want 0/1234", b0.rs_val, b0.rt_val);
    end
    wr(9, 32'h7);
    wr(10, 32'h8000_0000);
    wr(11, 32'h3020);
  endtask

  task automatic test_stall();
    logic [31:0] beq;
    beq = itype(6'h04, 8, 9, 16'h3);
    idle();
    b0.instr_f = beq; b0.pc_f = 32'h3040;
    tick();
    b0.e_addr = 8; b0.e_tnew = 2;
    #1;
    n_cmp++; if (b0.stall !== 1'b1 || b0.npc_sel !== 1'b0) begin n_bad++;
      $display("FAIL stall_e2: got %b/%b want 1/0", b0.stall, b0.npc_sel); end
    b0.instr_f = 0; b0.pc_f = 32'h3044;
    tick();
    n_cmp++; if (b0.instr_d !== beq || b0.pc_d !== 32'h3040) begin n_bad++;
      $display("FAIL hold: got %h@%h want %h@3040", b0.instr_d, b0.pc_d, beq);
    end
    b0.e_tnew = 1;
    #1;
    n_cmp++; if (b0.stall !== 1'b1) begin n_bad++;
      $display("FAIL stall_e1: got %b want 1", b0.stall); end
    tick();
    b0.e_addr = 0; b0.e_tnew = 0;
    b0.m_addr = 8; b0.m_tnew = 0; b0.m_data = 7;
    #1;
    n_cmp++; if (b0.stall !== 1'b0 || b0.rs_val !== 32'h7) begin n_bad++;
      $display("FAIL m_fwd: got %b/%h want 0/7", b0.stall, b0.rs_val); end
    n_cmp++; if (b0.npc_sel !== 1'b1 || b0.npc !== 32'h3050) begin n_bad++;
      $display("FAIL beq_tgt: got %b/%h want 1/3050", b0.npc_sel, b0.npc); end
    b0.m_addr = 0;
  endtask

  task automatic test_priority();
    idle();
    b0.instr_f = rtype(3, 3, 4, 6'h21);
    tick();
    b0.e_addr = 3; b0.e_tnew = 0; b0.e_data = 32'hA;
    b0.m_addr = 3; b0.m_tnew = 0; b0.m_data = 32'hB;
    b0.wb_we = 1; b0.wb_addr = 3; b0.wb_data = 32'hC;
    #1;
    n_cmp++; if (b0.rs_val !== 32'hA || b0.rt_val !== 32'hA) begin n_bad++;
      $display("FAIL prio_e: got %h/%h want a/a", b0.rs_val, b0.rt_val); end
    b0.e_tnew = 1;
    #1;
    n_cmp++; if (b0.stall !== 1'b0 || b0.rs_val !== 32'hB) begin n_bad++;
      $display("FAIL fall_m: got %b/%h want 0/b", b0.stall, b0.rs_val); end
    b0.e_tnew = 2;
    #1;
    n_cmp++; if (b0.stall !== 1'b1) begin n_bad++;
      $display("FAIL stall_addu: got %b want 1", b0.stall); end
    b0.e_addr = 0; b0.m_addr = 0;
    #1;
    n_cmp++; if (b0.rs_val !== 32'hC) begin n_bad++;
      $display("FAIL fall_wb: got %h want c", b0.rs_val); end
    b0.wb_we = 0;
  endtask

  task automatic test_imm();
    idle();
    b0.instr_f = itype(6'h0d, 1, 2, 16'h8001);
    tick();
    n_cmp++; if (b0.imm_ext !== 32'h8001 || b0.dst_d !== 5'd2) begin n_bad++;
      $display("FAIL ori: got %h/%0d want 8001/2", b0.imm_ext, b0.dst_d); end
    b0.instr_f = itype(6'h0f, 0, 7, 16'h8001);
    tick();
    n_cmp++; if (b0.imm_ext !== 32'h8001_0000 || b0.tnew_d !== 2'd2) begin
      n_bad++;
      $display("FAIL lui: got %h/%0d want 80010000/2", b0.imm_ext, b0.tnew_d);
    end
    b0.instr_f = itype(6'h23, 1, 3, 16'h8001);
    tick();
    n_cmp++; if (b0.imm_ext !== 32'hffff_8001 || b0.tnew_d !== 2'd3) begin
      n_bad++;
      $display("FAIL lw: got %h/%0d want ffff8001/3", b0.imm_ext, b0.tnew_d);
    end
    b0.instr_f = itype(6'h2b, 1, 12, 16'h4);
    tick();
    n_cmp++; if (b0.dst_d !== 5'd0 || b0.tnew_d !== 2'd0) begin n_bad++;
      $display("FAIL sw_dec: got %0d/%0d want 0/0", b0.dst_d, b0.tnew_d); end
    b0.e_addr = 12; b0.e_tnew = 3;
    #1;
    n_cmp++; if (b0.stall !== 1'b1) begin n_bad++;
      $display("FAIL sw_rt3: got %b want 1", b0.stall); end
    b0.e_tnew = 2;
    #1;
    n_cmp++; if (b0.stall !== 1'b0) begin n_bad++;
      $display("FAIL sw_rt2: got %b want 0", b0.stall); end
    b0.e_addr = 1;
    #1;
    n_cmp++; if (b0.stall !== 1'b1) begin n_bad++;
      $display("FAIL sw_rs2: got %b want 1", b0.stall); end
    b0.e_addr = 0; b0.e_tnew = 0;
    b0.instr_f = itype(6'h3f, 1, 2, 16'h1);
    tick();
    n_cmp++; if (b0.valid_d !== 1'b1 || b0.dst_d !== 5'd0
                 || b0.npc_sel !== 1'b0) begin n_bad++;
      $display("FAIL unk_op: got %b/%0d/%b want 1/0/0",
               b0.valid_d, b0.dst_d, b0.npc_sel); end
  endtask

  task automatic test_jal();
    logic [31:0] nxt;
    nxt = rtype(1, 2, 3, 6'h21);
    idle();
    b0.instr_f = {6'h03, 26'h100}; b0.pc_f = 32'h3010;
    tick();
    n_cmp++; if (b0.npc_sel !== 1'b1 || b0.npc !== 32'h400) begin n_bad++;
      $display("FAIL jal_ds1: got %b/%h want 1/400", b0.npc_sel, b0.npc); end
    n_cmp++; if (b1.npc_sel !== 1'b1 || b1.npc !== 32'h400) begin n_bad++;
      $display("FAIL jal_ds0: got %b/%h want 1/400", b1.npc_sel, b1.npc); end
    n_cmp++; if (b0.dst_d !== 5'd31 || b0.tnew_d !== 2'd1) begin n_bad++;
      $display("FAIL jal_dec: got %0d/%0d want 31/1", b0.dst_d, b0.tnew_d); end
    b0.instr_f = nxt; b0.pc_f = 32'h3014;
    tick();
    n_cmp++; if (b0.valid_d !== 1'b1 || b0.instr_d !== nxt) begin n_bad++;
      $display("FAIL slot_kept: got %b/%h want 1/%h",
               b0.valid_d, b0.instr_d, nxt); end
    n_cmp++; if (b1.valid_d !== 1'b0 || b1.instr_d !== 32'h0
                 || b1.npc_sel !== 1'b0) begin n_bad++;
      $display("FAIL flush: got %b/%h/%b want 0/0/0",
               b1.valid_d, b1.instr_d, b1.npc_sel); end
  endtask

  task automatic test_branch();
    idle();
    b0.instr_f = itype(6'h07, 10, 0, 16'h5);
    tick();
    n_cmp++; if (b0.npc_sel !== 1'b0) begin n_bad++;
      $display("FAIL bgtz_neg: got %b want 0", b0.npc_sel); end
    b0.instr_f = itype(6'h06, 10, 0, 16'h2); b0.pc_f = 32'h3080;
    tick();
    n_cmp++; if (b0.npc_sel !== 1'b1 || b0.npc !== 32'h308c) begin n_bad++;
      $display("FAIL blez_neg: got %b/%h want 1/308c", b0.npc_sel, b0.npc); end
    b0.instr_f = itype(6'h06, 0, 0, 16'hfffe); b0.pc_f = 32'h3084;
    tick();
    n_cmp++; if (b0.npc_sel !== 1'b1 || b0.npc !== 32'h3080) begin n_bad++;
      $display("FAIL blez_zero: got %b/%h want 1/3080", b0.npc_sel, b0.npc); end
    b0.instr_f = itype(6'h07, 9, 0, 16'h1); b0.pc_f = 32'h3088;
    tick();
    n_cmp++; if (b0.npc_sel !== 1'b1 || b0.npc !== 32'h3090) begin n_bad++;
      $display("FAIL bgtz_pos: got %b/%h want 1/3090", b0.npc_sel, b0.npc); end
    b0.instr_f = itype(6'h05, 10, 9, 16'h1);
    tick();
    n_cmp++; if (b0.npc_sel !== 1'b1) begin n_bad++;
      $display("FAIL bne_ne: got %b want 1", b0.npc_sel); end
    b0.instr_f = itype(6'h04, 10, 9, 16'h1);
    tick();
    n_cmp++; if (b0.npc_sel !== 1'b0) begin n_bad++;
      $display("FAIL beq_ne: got %b want 0", b0.npc_sel); end
    b0.instr_f = rtype(11, 0, 0, 6'h08); b0.pc_f = 32'h3090;
    tick();
    n_cmp++; if (b0.npc_sel !== 1'b1 || b0.npc !== 32'h3020) begin n_bad++;
      $display("FAIL jr: got %b/%h want 1/3020", b0.npc_sel, b0.npc); end
    b0.instr_f = {6'h02, 26'h3ff_ffff}; b0.pc_f = 32'hf000_0000;
    tick();
    n_cmp++; if (b0.npc !== 32'hffff_fffc) begin n_bad++;
      $display("FAIL j_tgt: got %h want fffffffc", b0.npc); end
  endtask

  task automatic test_reset_mid_stall();
    idle();
    b0.instr_f = itype(6'h04, 8, 9, 16'h3);
    tick();
    b0.e_addr = 8; b0.e_tnew = 2;
    #1;
    n_cmp++; if (b0.stall !== 1'b1) begin n_bad++;
      $display("FAIL pre_rst: got %b want 1", b0.stall); end
    #1 reset = 1;
    #1;
    n_cmp++; if (b0.stall !== 1'b0 || b0.instr_d !== 32'h0
                 || b0.valid_d !== 1'b0 || b0.pc_d !== 32'h3000) begin
      n_bad++;
      $display("FAIL mid_rst: got %b/%h/%b/%h want 0/0/0/3000",
               b0.stall, b0.instr_d, b0.valid_d, b0.pc_d); end
    reset = 0;
    b0.e_addr = 0; b0.e_tnew = 0;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_stall();
    test_priority();
    test_imm();
    test_jal();
    test_branch();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
